// File: rtl/pd_inout_f0f1_dec_pkg.sv
// Shared CLEFIA constants and the F0/F1 I/O controller state encoding.
package clefia_pkg;
    localparam int WORD_W  = 32;
    localparam int ROUND_W = 5;
    localparam int NR_128  = 18;
    localparam int NR_192  = 22;
    localparam int NR_256  = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/pd_inout_f0f1_dec_if.sv
// Data/handshake bundle between the F0/F1 decrypt I/O controller and its driver.
interface pd_inout_f0f1_dec_if;
    import clefia_pkg::*;

    logic                in_start;
    logic [WORD_W-1:0]   in_word;
    logic [WORD_W-1:0]   in_branch;
    logic [WORD_W-1:0]   in_F;
    logic [WORD_W-1:0]   in_wk;
    logic [WORD_W-1:0]   out_F;
    logic [WORD_W-1:0]   out_fb;
    logic [WORD_W-1:0]   out_result;
    logic [ROUND_W-1:0]  out_round;
    logic                out_busy;
    logic                out_done;

    modport master (
        output in_start, in_word, in_branch, in_F, in_wk,
        input  out_F, out_fb, out_result, out_round, out_busy, out_done
    );

    modport slave (
        input  in_start, in_word, in_branch, in_F, in_wk,
        output out_F, out_fb, out_result, out_round, out_busy, out_done
    );
endinterface

// File: rtl/pd_delay_line.sv
// PIPE-deep word-wide shift register; tail realigns feedback with F latency.
module pd_delay_line
    import clefia_pkg::*;
#(
    parameter int PIPE = 3,
    parameter int W    = WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] tail
);
    logic [PIPE-1:0][W-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else if (en) begin
            chain[0] <= d;
            for (int i = 1; i < PIPE; i++) chain[i] <= chain[i-1];
        end
    end

    assign tail = chain[PIPE-1];
endmodule

// File: rtl/pd_inout_f0f1_dec.sv
// CLEFIA GFN^-1 F0/F1 branch I/O controller: load, feedback delay, descending rounds.
// Optional in-block whitening with in_wk when PD_DEC_WHITEN_EN is defined.
module pd_inout_f0f1_dec
    import clefia_pkg::*;
#(
    parameter int NR   = 18,
    parameter int PIPE = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pd_inout_f0f1_dec_if.slave   bus
);
    localparam int PH_W = 3;
    localparam logic [ROUND_W-1:0] ROUND_TOP = ROUND_W'(NR - 1);
    localparam logic [PH_W-1:0]    PH_LAST   = PH_W'(PIPE - 1);

    state_t               state_q, state_d;
    logic [WORD_W-1:0]    load_q;
    logic [WORD_W-1:0]    result_q;
    logic [ROUND_W-1:0]   round_q;
    logic [PH_W-1:0]      phase_q;
    logic [WORD_W-1:0]    r;
    logic [WORD_W-1:0]    fb;
    logic [WORD_W-1:0]    cap_word;
    logic [WORD_W-1:0]    fin_word;
    logic                 in_round;
    logic                 last_phase;

    assign r          = bus.in_branch ^ bus.in_F;
    assign in_round   = (state_q == ROUND);
    assign last_phase = (phase_q == PH_LAST);

`ifdef PD_DEC_WHITEN_EN
    assign cap_word = bus.in_word ^ bus.in_wk;
    assign fin_word = r ^ bus.in_wk;
`else
    logic unused_wk;
    assign unused_wk = ^bus.in_wk;
    assign cap_word  = bus.in_word;
    assign fin_word  = r;
`endif

    pd_delay_line #(.PIPE(PIPE), .W(WORD_W)) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (in_round),
        .d    (r),
        .tail (fb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            load_q   <= '0;
            result_q <= '0;
            round_q  <= '0;
            phase_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.in_start) begin
                    load_q  <= cap_word;
                    round_q <= ROUND_TOP;
                end
                LOAD: phase_q <= '0;
                ROUND: begin
                    if (last_phase) begin
                        phase_q <= '0;
                        if (round_q != '0) round_q  <= round_q - 1'b1;
                        else               result_q <= fin_word;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_start) state_d = LOAD;
            LOAD:    state_d = ROUND;
            ROUND:   if (last_phase && round_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // First round consumes the loaded word; later rounds consume the realigned feedback.
    always_comb begin
        bus.out_F = '0;
        if (state_q == LOAD)                   bus.out_F = load_q;
        else if (in_round && round_q == ROUND_TOP) bus.out_F = load_q;
        else if (in_round)                     bus.out_F = fb;
    end

    assign bus.out_fb     = fb;
    assign bus.out_result = result_q;
    assign bus.out_round  = round_q;
    assign bus.out_busy   = (state_q == LOAD) || in_round;
    assign bus.out_done   = (state_q == DONE);
endmodule

// File: tb/tb_pd_inout_f0f1_dec.sv
// Directed bench for pd_inout_f0f1_dec at NR=2, PIPE=3 (whitening via PD_DEC_WHITEN_EN).
module tb_pd_inout_f0f1_dec;
    import clefia_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pd_inout_f0f1_dec_if bus ();

    pd_inout_f0f1_dec #(.NR(2), .PIPE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef PD_DEC_WHITEN_EN
    localparam logic [31:0] WK     = 32'hFFFF_FFFF;
    localparam logic [31:0] E_LOAD = 32'hFFFF_FFFE;
    localparam logic [31:0] E_RES1 = 32'hF0FF_FF0F;
    localparam logic [31:0] E_RES2 = 32'h0000_00F0;
`else
    localparam logic [31:0] WK     = 32'hA5A5_A5A5;
    localparam logic [31:0] E_LOAD = 32'h0000_0001;
    localparam logic [31:0] E_RES1 = 32'h0F00_00F0;
    localparam logic [31:0] E_RES2 = 32'hFFFF_FF0F;
`endif
    localparam logic [31:0] R1 = 32'h0F00_00F0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller sits in an IDLE cycle; returns in the DONE cycle (or after the bound).
    task automatic run_op(input string tag, input logic [31:0] e_load, input logic [31:0] e_res);
        int lat;
        bus.in_start = 1'b1;
        tick();
        bus.in_start = 1'b0;
        lat = 1;
        check({tag, "_load_F"}, bus.out_F, e_load);
        while (!bus.out_done && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_result"}, bus.out_result, e_res);
    endtask

    initial begin
        int dn;
        int dcyc;
        bus.in_start  = 1'b0;
        bus.in_word   = 32'h0000_0001;
        bus.in_branch = 32'h0F00_0000;
        bus.in_F      = 32'h0000_00F0;
        bus.in_wk     = WK;
        tick();
        tick();
        rst = 1'b0;

        check("rst_busy",   32'(bus.out_busy), 32'd0);
        check("rst_done",   32'(bus.out_done), 32'd0);
        check("rst_round",  32'(bus.out_round), 32'd0);
        check("rst_result", bus.out_result, 32'd0);
        check("rst_F",      bus.out_F, 32'd0);
        check("rst_fb",     bus.out_fb, 32'd0);

        // Scenario 1: cycle-by-cycle walk through one operation.
        bus.in_start = 1'b1;
        tick();
        bus.in_start = 1'b0;
        check("s1_load_busy",  32'(bus.out_busy), 32'd1);
        check("s1_load_F",     bus.out_F, E_LOAD);
        check("s1_load_round", 32'(bus.out_round), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("s1_round_%0d", k), 32'(bus.out_round), (k < 3) ? 32'd1 : 32'd0);
            check($sformatf("s1_F_%0d", k), bus.out_F, (k < 3) ? E_LOAD : R1);
            check($sformatf("s1_busy_%0d", k), 32'(bus.out_busy), 32'd1);
            if (k >= 3) check($sformatf("s1_fb_%0d", k), bus.out_fb, R1);
        end
        tick();
        check("s1_done",   32'(bus.out_done), 32'd1);
        check("s1_busy_d", 32'(bus.out_busy), 32'd0);
        check("s1_result", bus.out_result, E_RES1);
        check("s1_F_done", bus.out_F, 32'd0);
        tick();
        check("s1_done_clr", 32'(bus.out_done), 32'd0);
        check("s1_hold",     bus.out_result, E_RES1);

        // Scenario 2: stray start while busy must be ignored.
        bus.in_start = 1'b1;
        tick();
        bus.in_start = 1'b0;
        tick();
        tick();
        bus.in_start = 1'b1;
        dn = 0;
        dcyc = 0;
        for (int c = 3; c <= 10; c++) begin
            tick();
            bus.in_start = 1'b0;
            if (bus.out_done) begin
                dn++;
                dcyc = c + 1;
            end
        end
        check("s2_done_count", 32'(dn), 32'd1);
        check("s2_done_cycle", 32'(dcyc), 32'd8);
        check("s2_result",     bus.out_result, E_RES1);
        check("s2_idle",       32'(bus.out_busy), 32'd0);

        // Scenario 3: reset mid-operation, then a clean run.
        bus.in_start = 1'b1;
        tick();
        bus.in_start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s3_busy",   32'(bus.out_busy), 32'd0);
        check("s3_round",  32'(bus.out_round), 32'd0);
        check("s3_result", bus.out_result, 32'd0);
        check("s3_done",   32'(bus.out_done), 32'd0);
        check("s3_fb",     bus.out_fb, 32'd0);
        tick();
        check("s3_no_done", 32'(bus.out_done), 32'd0);
        run_op("s3_rerun", E_LOAD, E_RES1);

        // Scenario 4: back-to-back start in the cycle after DONE.
        bus.in_branch = 32'hFFFF_FFFF;
        tick();
        run_op("s4_b2b", E_LOAD, E_RES2);
        check("s4_round_end", 32'(bus.out_round), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
